// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bp_pkg
// Brief   : Shared types and 2-bit saturating counter helper for the gshare predictor.
// Rev     : 1.0
// ============================================================================
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_CTR_SNT = 2'b00;
    localparam bp_ctr_t BP_CTR_WNT = 2'b01;
    localparam bp_ctr_t BP_CTR_WT  = 2'b10;
    localparam bp_ctr_t BP_CTR_ST  = 2'b11;

    function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
        bp_ctr_t n;
        n = c;
        if (taken) begin
            if (c != BP_CTR_ST) n = c + 2'd1;
        end else begin
            if (c != BP_CTR_SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_ghr_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : bp_ghr_shift_reg
// Brief   : Global history shift register; newest outcome enters at bit 0.
// Rev     : 1.0
// ============================================================================
module bp_ghr_shift_reg #(
    parameter int p_nbits = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               shift_in,
    output logic [p_nbits-1:0] q
);

    generate
        if (p_nbits == 1) begin : g_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (shift_en) begin
                    q <= shift_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (shift_en) begin
                    q <= {q[p_nbits-2:0], shift_in};
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bp_gshare_pht.sv
`default_nettype none
// ============================================================================
// Module  : bp_gshare_pht
// Brief   : Gshare direction predictor with a one-entry registered response buffer.
// Rev     : 1.0
// ============================================================================
module bp_gshare_pht
    import bp_pkg::*;
#(
    parameter int p_idx_nbits = 7,
    parameter int p_ghr_nbits = 7,
    parameter int p_pc_nbits  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [p_pc_nbits-1:0]  req_pc,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_taken,
    output logic [p_idx_nbits-1:0] resp_idx,
    input  logic                   upd_val,
    input  logic [p_idx_nbits-1:0] upd_idx,
    input  logic                   upd_taken
);

    localparam int PHT_ENTRIES = 2 ** p_idx_nbits;

    logic [p_ghr_nbits-1:0] ghr;
    logic [p_idx_nbits-1:0] idx;
    logic                   req_fire;
    logic                   unused_pc_bits;
    bp_ctr_t                pht [PHT_ENTRIES];

    // Word-aligned PC bits below and tag bits above the index field do not matter.
    assign unused_pc_bits = ^{req_pc[p_pc_nbits-1:p_idx_nbits+2], req_pc[1:0]};

    bp_ghr_shift_reg #(
        .p_nbits (p_ghr_nbits)
    ) u_ghr (
        .clk      (clk),
        .reset    (reset),
        .shift_en (upd_val),
        .shift_in (upd_taken),
        .q        (ghr)
    );

    assign idx      = req_pc[p_idx_nbits+1:2] ^ p_idx_nbits'(ghr);
    assign req_rdy  = !resp_val || resp_rdy;
    assign req_fire = req_val && req_rdy;

    // Flop array so the whole table returns to weakly-not-taken in one reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= BP_CTR_WNT;
            end
        end else if (upd_val) begin
            pht[upd_idx] <= bp_ctr_next(pht[upd_idx], upd_taken);
        end
    end

    // Reads use pre-edge PHT and GHR, so a same-cycle update is not forwarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_val   <= 1'b0;
            resp_taken <= 1'b0;
            resp_idx   <= '0;
        end else if (req_fire) begin
            resp_val   <= 1'b1;
            resp_taken <= pht[idx][1];
            resp_idx   <= idx;
        end else if (resp_rdy) begin
            resp_val   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_gshare_pht.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_gshare_pht
// Brief   : Directed self-checking bench with reference model and response scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_bp_gshare_pht;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_pc;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_taken;
    logic [6:0]  resp_idx;
    logic        upd_val;
    logic [6:0]  upd_idx;
    logic        upd_taken;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0] m_pht [128];
    logic [6:0] m_ghr;
    logic       m_resp_val;
    logic [7:0] sb [$];

    bp_gshare_pht #(
        .p_idx_nbits (7),
        .p_ghr_nbits (7),
        .p_pc_nbits  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_pc     (req_pc),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_taken (resp_taken),
        .resp_idx   (resp_idx),
        .upd_val    (upd_val),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_pht[i] = 2'b01;
        m_ghr      = '0;
        m_resp_val = 1'b0;
        sb.delete();
    endtask

    function automatic logic [31:0] pc_for(input logic [6:0] i);
        logic [31:0] r;
        r      = $urandom();
        r[8:2] = i ^ m_ghr;
        return r;
    endfunction

    // One clock: compare at the negedge, advance the model, return just after the posedge.
    task automatic cycle();
        logic       fire;
        logic [6:0] midx;
        @(negedge clk);
        check("req_rdy", {31'd0, req_rdy}, {31'd0, (!m_resp_val || resp_rdy)});
        check("resp_val", {31'd0, resp_val}, {31'd0, m_resp_val});
        if (m_resp_val && sb.size() > 0) begin
            check("resp_idx", {25'd0, resp_idx}, {25'd0, sb[0][6:0]});
            check("resp_taken", {31'd0, resp_taken}, {31'd0, sb[0][7]});
            if (resp_rdy) void'(sb.pop_front());
        end
        fire = req_val && (!m_resp_val || resp_rdy);
        if (fire) begin
            midx = req_pc[8:2] ^ m_ghr;
            sb.push_back({m_pht[midx][1], midx});
        end
        if (upd_val) begin
            if (upd_taken && m_pht[upd_idx] != 2'b11) m_pht[upd_idx] = m_pht[upd_idx] + 2'd1;
            if (!upd_taken && m_pht[upd_idx] != 2'b00) m_pht[upd_idx] = m_pht[upd_idx] - 2'd1;
            m_ghr = {m_ghr[5:0], upd_taken};
        end
        if (fire) m_resp_val = 1'b1;
        else if (resp_rdy) m_resp_val = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_val  = 1'b0;
        upd_val  = 1'b0;
        resp_rdy = 1'b1;
        cycle();
    endtask

    task automatic upd(input logic [6:0] i, input logic t);
        req_val   = 1'b0;
        upd_val   = 1'b1;
        upd_idx   = i;
        upd_taken = t;
        cycle();
        upd_val   = 1'b0;
    endtask

    task automatic probe(input logic [6:0] i);
        req_val  = 1'b1;
        req_pc   = pc_for(i);
        resp_rdy = 1'b1;
        upd_val  = 1'b0;
        cycle();
        req_val  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        req_val   = 1'b0;
        req_pc    = '0;
        resp_rdy  = 1'b1;
        upd_val   = 1'b0;
        upd_idx   = '0;
        upd_taken = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("reset_resp_val", {31'd0, resp_val}, 32'd0);
        check("reset_resp_idx", {25'd0, resp_idx}, 32'd0);
        check("reset_resp_taken", {31'd0, resp_taken}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_req_rdy", {31'd0, req_rdy}, 32'd1);

        // Basic prediction from a fresh table.
        req_val = 1'b1;
        req_pc  = 32'h0000_0010;
        cycle();
        req_val = 1'b0;
        check("t1_resp_val", {31'd0, resp_val}, 32'd1);
        check("t1_resp_idx", {25'd0, resp_idx}, 32'd4);
        check("t1_resp_taken", {31'd0, resp_taken}, 32'd0);

        // History folds into the index.
        upd(7'd4, 1'b1);
        upd(7'd4, 1'b1);
        req_val  = 1'b1;
        req_pc   = 32'h0000_0010;
        cycle();
        check("t2_idx_hashed", {25'd0, resp_idx}, 32'd7);
        check("t2_taken_7", {31'd0, resp_taken}, 32'd0);
        req_pc   = 32'h0000_001C;
        cycle();
        req_val  = 1'b0;
        check("t2_idx_4", {25'd0, resp_idx}, 32'd4);
        check("t2_taken_4", {31'd0, resp_taken}, 32'd1);
        idle();

        // Saturation at both ends of the counter.
        repeat (5) upd(7'd9, 1'b0);
        upd(7'd9, 1'b1);
        probe(7'd9);
        check("t3_low_sat", {31'd0, resp_taken}, 32'd0);
        repeat (5) upd(7'd9, 1'b1);
        probe(7'd9);
        check("t3_high_sat", {31'd0, resp_taken}, 32'd1);
        upd(7'd9, 1'b0);
        probe(7'd9);
        check("t3_high_sat_dec", {31'd0, resp_taken}, 32'd1);
        idle();

        // Backpressure with a request held pending.
        req_val  = 1'b1;
        resp_rdy = 1'b0;
        req_pc   = pc_for(7'd30);
        cycle();
        for (int k = 0; k < 3; k++) begin
            req_pc = $urandom();
            cycle();
            check("t4_stall_req_rdy", {31'd0, req_rdy}, 32'd0);
            check("t4_stall_resp_val", {31'd0, resp_val}, 32'd1);
        end
        resp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_pc = $urandom();
            cycle();
            check("t4_throughput", {31'd0, resp_val}, 32'd1);
        end
        req_val = 1'b0;
        idle();

        // Same-cycle update and request on one index reads the old counter.
        req_val   = 1'b1;
        req_pc    = pc_for(7'd20);
        upd_val   = 1'b1;
        upd_idx   = 7'd20;
        upd_taken = 1'b1;
        cycle();
        upd_val   = 1'b0;
        req_val   = 1'b0;
        check("t5_rbw_idx", {25'd0, resp_idx}, 32'd20);
        check("t5_rbw_taken", {31'd0, resp_taken}, 32'd0);
        probe(7'd20);
        check("t5_after_taken", {31'd0, resp_taken}, 32'd1);
        idle();

        // Asynchronous reset while a response is stalled.
        req_val  = 1'b1;
        resp_rdy = 1'b0;
        req_pc   = pc_for(7'd55);
        cycle();
        req_val  = 1'b0;
        check("t6_pre_resp_val", {31'd0, resp_val}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_resp_val", {31'd0, resp_val}, 32'd0);
        check("t6_async_resp_idx", {25'd0, resp_idx}, 32'd0);
        check("t6_async_req_rdy", {31'd0, req_rdy}, 32'd1);
        model_reset();
        @(negedge clk);
        reset    = 1'b1;
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("t6_post_req_rdy", {31'd0, req_rdy}, 32'd1);
        req_val = 1'b1;
        req_pc  = 32'h0000_0010;
        cycle();
        check("t6_ghr_cleared_idx", {25'd0, resp_idx}, 32'd4);
        check("t6_pht4_cleared", {31'd0, resp_taken}, 32'd0);
        for (int i = 0; i < 128; i++) begin
            req_pc = pc_for(7'(i));
            cycle();
            check("t6_pht_sweep", {31'd0, resp_taken}, 32'd0);
        end
        req_val = 1'b0;
        idle();
        idle();
        check("final_sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
